// File: rtl/ahb5_mem_slave_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb5_mem_slave_pkg: AHB encodings and FSM state type for ahb5_mem_slave.
// Rev 1.0
// ----------------------------------------------------------------------------
package ahb5_mem_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR1 = 2'b10,
    ST_ERR2 = 2'b11
  } state_t;

  function automatic logic trans_active(input logic [1:0] trans);
    return (trans != HTRANS_IDLE) && (trans != HTRANS_BUSY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb5_mem_slave_array.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb5_mem_slave_array: byte-lane writable word storage with asynchronous read.
// Rev 1.0
// ----------------------------------------------------------------------------
module ahb5_mem_slave_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] wr_en,
  input  logic [IDX_W-1:0]        idx,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  localparam int LANES = DATA_WIDTH / 8;

  // Contents are intentionally not reset.
  logic [LANES-1:0][7:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        mem[idx][i] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem[idx];

endmodule
`default_nettype wire

// File: rtl/ahb5_mem_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb5_mem_slave: AHB5 memory slave; AHB5_MEM_SLAVE_WAIT_EN enables wait states.
// Rev 1.0
// ----------------------------------------------------------------------------
module ahb5_mem_slave
  import ahb5_mem_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int LANES = DATA_WIDTH / 8;

  state_t                  state;
  logic                    ph_valid;
  logic                    ph_write;
  logic [ADDR_WIDTH-1:0]   ph_addr;
  logic [2:0]              ph_size;
`ifdef AHB5_MEM_SLAVE_WAIT_EN
  logic [2:0]              wait_cnt;
`endif

  logic                    capture;
  logic                    addr_err;
  logic                    final_okay;
  logic [LANES-1:0]        lane_en;
  logic [LANES-1:0]        wr_en;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused;

  // Only a cycle in which this slave is ready can end the current data phase.
  assign capture    = HSEL && HREADY && HREADYOUT && trans_active(HTRANS);
  assign final_okay = (state == ST_IDLE) && ph_valid;

  always_comb begin
    addr_err = 1'b0;
    if ({2'b00, HADDR[ADDR_WIDTH-1:2]} >= ADDR_WIDTH'(MEM_DEPTH)) addr_err = 1'b1;
    if (HSIZE > HSIZE_WORD) addr_err = 1'b1;
    if ((HSIZE == HSIZE_HALF) && HADDR[0]) addr_err = 1'b1;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) addr_err = 1'b1;
  end

  always_comb begin
    lane_en = '0;
    case (ph_size)
      HSIZE_BYTE: lane_en = LANES'(1) << ph_addr[1:0];
      HSIZE_HALF: lane_en = LANES'(3) << {ph_addr[1], 1'b0};
      default:    lane_en = '1;
    endcase
  end

  assign wr_en  = (final_okay && ph_write) ? lane_en : '0;
  assign HRDATA = (final_okay && !ph_write) ? rd_data : '0;
  assign unused = ^{HBURST, ph_addr, 3'(WAIT_CYCLES)};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      ph_valid  <= 1'b0;
      ph_write  <= 1'b0;
      ph_addr   <= '0;
      ph_size   <= '0;
`ifdef AHB5_MEM_SLAVE_WAIT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      case (state)
`ifdef AHB5_MEM_SLAVE_WAIT_EN
        ST_WAIT: begin
          if (wait_cnt <= 3'd1) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
          end
          wait_cnt <= wait_cnt - 3'd1;
        end
`endif
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
        end
        default: begin
          // IDLE or ERR2: the current data phase (if any) ends here.
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_OKAY;
          ph_valid  <= 1'b0;
          if (capture) begin
            ph_addr  <= HADDR;
            ph_write <= HWRITE;
            ph_size  <= HSIZE;
            if (addr_err) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= HRESP_ERROR;
            end else begin
              ph_valid <= 1'b1;
`ifdef AHB5_MEM_SLAVE_WAIT_EN
              if (WAIT_CYCLES != 0) begin
                state     <= ST_WAIT;
                HREADYOUT <= 1'b0;
                wait_cnt  <= 3'(WAIT_CYCLES);
              end
`endif
            end
          end
        end
      endcase
    end
  end

  ahb5_mem_slave_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (HCLK),
    .wr_en   (wr_en),
    .idx     (ph_addr[IDX_W+1:2]),
    .wr_data (HWDATA),
    .rd_data (rd_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_ahb5_mem_slave.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ahb5_mem_slave: random AHB traffic checked against a byte-level memory model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ahb5_mem_slave;

  localparam int DEPTH = 1024;
`ifdef AHB5_MEM_SLAVE_WAIT_EN
  localparam int WAITS = 2;
`else
  localparam int WAITS = 0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        HSEL = 1'b0;
  logic        HWRITE = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] HADDR = '0;
  logic [31:0] HWDATA = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic [2:0]  HSIZE = 3'b000;
  logic [2:0]  HBURST = 3'b000;
  wire         HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  assign HREADY = HREADYOUT && !hold;

  always #5 HCLK = ~HCLK;

  ahb5_mem_slave #(
    .ADDR_WIDTH  (32),
    .DATA_WIDTH  (32),
    .MEM_DEPTH   (DEPTH),
    .WAIT_CYCLES (2)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HBURST    (HBURST),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA)
  );

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  mem_b[int];
  int          compared = 0;
  int          failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    failed++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: byte-addressed memory and the error rules.
  function automatic bit model_err(input logic [31:0] a, input logic [2:0] s);
    return (a / 4 >= DEPTH) || (s > 2) || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0);
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    for (int b = 0; b < (1 << s); b++) begin
      int ba;
      ba = int'(a) + b;
      mem_b[ba] = d[8*(ba % 4) +: 8];
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int base;
    base = int'(a) - int'(a % 4);
    return {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
  endfunction

  // Monitor: follows data phases from bus activity and checks each against the queue.
  bit in_dp = 0;
  int low_cnt = 0;
  bit low_resp_or = 0;
  bit low_resp_and = 1;
  bit low_data_nz = 0;

  always @(negedge HCLK) begin
    if (!HRESETn) begin
      in_dp = 0;
    end else begin
      if (in_dp) begin
        if (!HREADYOUT) begin
          low_cnt++;
          low_resp_or  = low_resp_or | HRESP;
          low_resp_and = low_resp_and & HRESP;
          if (HRDATA != 32'h0) low_data_nz = 1;
          if (low_cnt > 16) begin
            fail_now("dp_timeout");
            in_dp = 0;
          end
        end else begin
          if (sb.size() == 0) begin
            fail_now("unexpected_data_phase");
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("hresp", 32'(HRESP), 32'(e.err));
            chk("wait_cycles", low_cnt, e.err ? 1 : WAITS);
            chk("wait_resp", 32'(e.err ? (low_resp_and && low_cnt > 0) : !low_resp_or), 32'd1);
            chk("wait_hrdata", 32'(low_data_nz), 32'd0);
            chk("hrdata", HRDATA, (e.rd && !e.err) ? e.rdata : 32'h0);
          end
          in_dp = 0;
        end
      end else begin
        chk("idle_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("idle_hresp", 32'(HRESP), 32'd0);
        chk("idle_hrdata", HRDATA, 32'h0);
      end
      if (HSEL && HREADY && HTRANS[1]) begin
        in_dp        = 1;
        low_cnt      = 0;
        low_resp_or  = 0;
        low_resp_and = 1;
        low_data_nz  = 0;
      end
    end
  end

  task automatic wait_accept(output bit ok);
    int n;
    n = 0;
    do begin
      @(posedge HCLK);
      n++;
    end while (!HREADY && n < 50);
    ok = HREADY;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                       input logic [31:0] data);
    bit   ok;
    exp_t e;
    HSEL   = 1'b1;
    HTRANS = ($urandom_range(1) == 0) ? 2'b10 : 2'b11;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HBURST = 3'($urandom_range(7));
    wait_accept(ok);
    if (ok) begin
      e.err   = model_err(addr, size);
      e.rd    = !wr;
      e.rdata = 32'h0;
      if (!e.err && !wr) e.rdata = model_read(addr);
      if (!e.err && wr) model_write(addr, size, data);
      sb.push_back(e);
    end
    #1;
    HWDATA = wr ? data : $urandom;
  endtask

  task automatic idle_cycle();
    HSEL   = 1'($urandom_range(1));
    HTRANS = ($urandom_range(1) == 0) ? 2'b00 : 2'b01;
    @(posedge HCLK);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    while ((sb.size() != 0 || in_dp) && n < 100) begin
      @(posedge HCLK);
      #1;
      n++;
    end
    if (n >= 100) fail_now("drain_timeout");
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    logic [31:0] addr;
    logic [2:0]  size;

    repeat (3) @(posedge HCLK);
    #1;
    chk("reset_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("reset_hresp", 32'(HRESP), 32'd0);
    chk("reset_hrdata", HRDATA, 32'h0);
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Give every word the bench will read a known value.
    for (int w = 0; w < 16; w++) issue(1'b1, 32'(4 * w), 3'b010, $urandom);
    issue(1'b1, 32'hFFC, 3'b010, $urandom);
    drain();

    issue(1'b1, 32'h10, 3'b010, 32'hDEADBEEF);
    drain();
    issue(1'b0, 32'h10, 3'b010, 32'h0);
    drain();

    issue(1'b1, 32'h10, 3'b010, 32'h11223344);
    issue(1'b1, 32'h13, 3'b000, 32'hAA000000);
    issue(1'b0, 32'h10, 3'b010, 32'h0);
    drain();

    issue(1'b0, 32'h1000, 3'b010, 32'h0);
    issue(1'b1, 32'h1000, 3'b010, 32'hFFFFFFFF);
    issue(1'b0, 32'h0, 3'b010, 32'h0);
    issue(1'b0, 32'h10, 3'b010, 32'h0);
    drain();

    issue(1'b0, 32'h1, 3'b001, 32'h0);
    issue(1'b1, 32'h1, 3'b001, 32'h12345678);
    issue(1'b1, 32'h2, 3'b010, 32'h87654321);
    issue(1'b1, 32'h4, 3'b011, 32'h0BADF00D);
    issue(1'b0, 32'h0, 3'b010, 32'h0);
    issue(1'b0, 32'h4, 3'b010, 32'h0);
    drain();

    // Reset during the data phase of a write must abort it.
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = 32'h20;
    HWRITE = 1'b1;
    HSIZE  = 3'b010;
    wait_accept(ok);
    #1;
    HWDATA  = 32'h55;
    HSEL    = 1'b0;
    HTRANS  = 2'b00;
    HRESETn = 1'b0;
    #1;
    chk("abort_hreadyout", 32'(HREADYOUT), 32'd1);
    chk("abort_hresp", 32'(HRESP), 32'd0);
    chk("abort_hrdata", HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    @(posedge HCLK);
    #1;
    issue(1'b0, 32'h20, 3'b010, 32'h0);
    drain();

    issue(1'b1, 32'h8, 3'b010, 32'hCAFEF00D);
    issue(1'b0, 32'h8, 3'b010, 32'h0);
    issue(1'b1, 32'hA, 3'b001, 32'h5A5A0000);
    issue(1'b0, 32'h8, 3'b010, 32'h0);
    drain();

    // Address phases that must be ignored: HREADY low, then HSEL low.
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HADDR  = 32'h4;
    HWRITE = 1'b1;
    HSIZE  = 3'b010;
    HWDATA = 32'hF0F0F0F0;
    hold   = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    HSEL   = 1'b0;
    hold   = 1'b0;
    @(posedge HCLK);
    #1;
    HTRANS = 2'b10;
    HADDR  = 32'hC;
    repeat (3) @(posedge HCLK);
    #1;
    HTRANS = 2'b00;
    issue(1'b0, 32'h4, 3'b010, 32'h0);
    issue(1'b0, 32'hC, 3'b010, 32'h0);
    drain();

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(99) < 10) begin
        idle_cycle();
      end else begin
        size = ($urandom_range(19) == 0) ? 3'($urandom_range(7, 3)) : 3'($urandom_range(2));
        case ($urandom_range(14))
          0:       addr = 32'h1000 + 32'($urandom_range(255));
          1:       addr = 32'hFFC + 32'($urandom_range(3));
          default: addr = 32'($urandom_range(63));
        endcase
        if (size <= 3'd2 && $urandom_range(3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
        issue(1'($urandom_range(1)), addr, size, $urandom);
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
`default_nettype wire
